// File: rtl/config_write_ctrl.sv
// config_write_ctrl: write / verify / scrub controller for N_CELLS 8-bit
// configuration cells that share one data bus.
//   clk, rstn            clock and asynchronous active-low reset
//   cmd_valid/cmd_ready  write command handshake (ready only in IDLE)
//   cmd_addr, cmd_data   target cell index and value to write
//   scrub_en             enables periodic re-load of each cell with its own output
//   err_clr              clears sticky err / err_addr
//   cfg_din, cfg_load    shared data bus and one-hot load strobe to the cells
//   cfg_q                cell outputs, cell i at [8*i+7:8*i]
//   done                 1-cycle pulse when a command finishes
//   err, err_addr        sticky error flag and address of the first error
module config_write_ctrl #(
    parameter int unsigned N_CELLS      = 8,
    parameter int unsigned AW           = 3,
    parameter int unsigned MAX_RETRY    = 2,
    parameter int unsigned SCRUB_PERIOD = 1024,
    parameter int unsigned SCRUB_CW     = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [7:0]             cmd_data,
    input  logic                   scrub_en,
    input  logic                   err_clr,
    output logic [7:0]             cfg_din,
    output logic [N_CELLS-1:0]     cfg_load,
    input  logic [8*N_CELLS-1:0]   cfg_q,
    output logic                   done,
    output logic                   err,
    output logic [AW-1:0]          err_addr
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SCRUB
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_addr,     w_addr_nxt;
    logic [7:0]           r_data,     w_data_nxt;
    logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
    logic [AW-1:0]        r_ptr,      w_ptr_nxt;
    logic [SCRUB_CW-1:0]  r_timer;
    logic                 r_pend;
    logic [N_CELLS-1:0]   r_load,     w_load_nxt;
    logic [7:0]           r_din,      w_din_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_err,      w_err_nxt;
    logic [AW-1:0]        r_err_addr, w_err_addr_nxt;
    logic                 w_new_err;
    logic [AW-1:0]        w_err_src;
    logic                 w_scrub_clr;
    logic                 w_in_range;
    logic [7:0]           w_q_addr;
    logic [7:0]           w_q_ptr;

    function automatic logic [N_CELLS-1:0] f_onehot(input logic [AW-1:0] idx);
        f_onehot = N_CELLS'(1) << idx;
    endfunction

    assign cmd_ready  = (r_state == S_IDLE);
    assign cfg_load   = r_load;
    assign cfg_din    = r_din;
    assign done       = r_done;
    assign err        = r_err;
    assign err_addr   = r_err_addr;
    assign w_in_range = (32'(cmd_addr) < 32'(N_CELLS));

    // Select the readback of the command target and of the scrub pointer
    always_comb begin
        w_q_addr = 8'h00;
        w_q_ptr  = 8'h00;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            if (r_addr == AW'(i)) w_q_addr = cfg_q[8*i +: 8];
            if (r_ptr  == AW'(i)) w_q_ptr  = cfg_q[8*i +: 8];
        end
    end

    // Next-state and next-output logic; strobes are computed on the
    // transition into LOAD/SCRUB so they are registered during that state
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_load_nxt  = '0;
        w_din_nxt   = r_din;
        w_done_nxt  = 1'b0;
        w_new_err   = 1'b0;
        w_err_src   = r_addr;
        w_scrub_clr = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_addr_nxt = cmd_addr;
                    w_data_nxt = cmd_data;
                    w_cnt_nxt  = '0;
                    if (w_in_range) begin
                        w_state_nxt = S_LOAD;
                        w_load_nxt  = f_onehot(cmd_addr);
                        w_din_nxt   = cmd_data;
                    end else begin
                        w_done_nxt = 1'b1;
                        w_new_err  = 1'b1;
                        w_err_src  = cmd_addr;
                    end
                end else if (r_pend) begin
                    // Re-load the cell with its own current output
                    w_state_nxt = S_SCRUB;
                    w_load_nxt  = f_onehot(r_ptr);
                    w_din_nxt   = w_q_ptr;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_q_addr == r_data) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt < CNT_W'(MAX_RETRY)) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_load_nxt  = f_onehot(r_addr);
                    w_din_nxt   = r_data;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_new_err   = 1'b1;
                end
            end
            S_SCRUB: begin
                w_state_nxt = S_IDLE;
                w_scrub_clr = 1'b1;
                w_ptr_nxt   = (r_ptr == AW'(N_CELLS - 1)) ? '0 : r_ptr + AW'(1);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Sticky error: only the first error is recorded, but a new error
        // coinciding with err_clr wins over the clear
        w_err_nxt      = r_err;
        w_err_addr_nxt = r_err_addr;
        if (err_clr) begin
            w_err_nxt      = 1'b0;
            w_err_addr_nxt = '0;
        end
        if (w_new_err && (!r_err || err_clr)) begin
            w_err_nxt      = 1'b1;
            w_err_addr_nxt = w_err_src;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_load     <= '0;
            r_din      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_load     <= w_load_nxt;
            r_din      <= w_din_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_addr <= w_err_addr_nxt;
        end
    end

    // Scrub timer: one pending request at most; ticks while pending are dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_timer <= '0;
            r_pend  <= 1'b0;
        end else if (!scrub_en) begin
            r_timer <= '0;
            r_pend  <= 1'b0;
        end else begin
            if (r_timer == SCRUB_CW'(SCRUB_PERIOD - 1)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + SCRUB_CW'(1);
            end
            if (w_scrub_clr) begin
                r_pend <= 1'b0;
            end else if (r_timer == SCRUB_CW'(SCRUB_PERIOD - 1)) begin
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_config_write_ctrl.sv
// Directed bench for config_write_ctrl with a behavioural model of 8 cells.
module tb_config_write_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        scrub_en;
    logic        err_clr;
    logic [7:0]  cfg_din;
    logic [7:0]  cfg_load;
    logic [63:0] cfg_q;
    logic        done;
    logic        err;
    logic [3:0]  err_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] cells [8] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    int         load_cnt [8] = '{default: 0};
    logic       stuck5   = 1'b0;
    logic       poke_en  = 1'b0;
    logic [2:0] poke_idx = 3'd0;
    logic [7:0] poke_val = 8'h00;

    config_write_ctrl #(
        .N_CELLS(8), .AW(4), .MAX_RETRY(2), .SCRUB_PERIOD(16), .SCRUB_CW(4)
    ) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .scrub_en(scrub_en),
        .err_clr(err_clr), .cfg_din(cfg_din), .cfg_load(cfg_load), .cfg_q(cfg_q),
        .done(done), .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // Cell array model: each cell loads cfg_din when its strobe is high
    always @(posedge clk) begin
        if (poke_en) cells[poke_idx] <= poke_val;
        for (int i = 0; i < 8; i++) begin
            if (cfg_load[i]) begin
                cells[i]    <= cfg_din;
                load_cnt[i] <= load_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        cfg_q = '0;
        for (int i = 0; i < 8; i++) cfg_q[8*i +: 8] = cells[i];
        if (stuck5) cfg_q[47:40] = 8'h00;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        scrub_en = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (cfg_load !== 8'h00) begin errors++; $display("FAIL reset_load got=%h exp=00", cfg_load); end
        checks++; if (cfg_din !== 8'h00) begin errors++; $display("FAIL reset_din got=%h exp=00", cfg_din); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (err_addr !== 4'd0) begin errors++; $display("FAIL reset_err_addr got=%0d exp=0", err_addr); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write;
        int c3;
        c3 = load_cnt[3];
        cmd_valid = 1'b1; cmd_addr = 4'd3; cmd_data = 8'hA5;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cfg_load !== 8'h08) begin errors++; $display("FAIL wr_load got=%h exp=08", cfg_load); end
        checks++; if (cfg_din !== 8'hA5) begin errors++; $display("FAIL wr_din got=%h exp=a5", cfg_din); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_busy got=%b exp=0", cmd_ready); end
        tick();
        checks++; if (cfg_load !== 8'h00) begin errors++; $display("FAIL wr_check_load got=%h exp=00", cfg_load); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_early_done got=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wr_done got=%b exp=1", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", err); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got=%b exp=1", cmd_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got=%b exp=0", done); end
        checks++; if (cells[3] !== 8'hA5) begin errors++; $display("FAIL wr_cell3 got=%h exp=a5", cells[3]); end
        checks++; if (load_cnt[3] - c3 !== 1) begin errors++; $display("FAIL wr_nloads got=%0d exp=1", load_cnt[3] - c3); end
    endtask

    task automatic test_retry;
        int c5;
        int n;
        stuck5 = 1'b1;
        c5 = load_cnt[5];
        cmd_valid = 1'b1; cmd_addr = 4'd5; cmd_data = 8'h3C;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n !== 6) begin errors++; $display("FAIL retry_latency got=%0d exp=6", n); end
        checks++; if (load_cnt[5] - c5 !== 3) begin errors++; $display("FAIL retry_nloads got=%0d exp=3", load_cnt[5] - c5); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL retry_err got=%b exp=1", err); end
        checks++; if (err_addr !== 4'd5) begin errors++; $display("FAIL retry_err_addr got=%0d exp=5", err_addr); end
        stuck5 = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL retry_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_bad_addr;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err got=%b exp=0", err); end
        checks++; if (err_addr !== 4'd0) begin errors++; $display("FAIL clr_err_addr got=%0d exp=0", err_addr); end
        cmd_valid = 1'b1; cmd_addr = 4'd9; cmd_data = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cfg_load !== 8'h00) begin errors++; $display("FAIL bad_load got=%h exp=00", cfg_load); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bad_done got=%b exp=1", done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", err); end
        checks++; if (err_addr !== 4'd9) begin errors++; $display("FAIL bad_err_addr got=%0d exp=9", err_addr); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bad_ready got=%b exp=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_addr = 4'd12;
        tick();
        cmd_valid = 1'b0;
        checks++; if (err_addr !== 4'd9) begin errors++; $display("FAIL first_err_kept got=%0d exp=9", err_addr); end
        cmd_valid = 1'b1; cmd_addr = 4'd14; err_clr = 1'b1;
        tick();
        cmd_valid = 1'b0; err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_vs_new_err got=%b exp=1", err); end
        checks++; if (err_addr !== 4'd14) begin errors++; $display("FAIL clr_vs_new_addr got=%0d exp=14", err_addr); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr2_err got=%b exp=0", err); end
    endtask

    task automatic test_scrub;
        int n;
        logic [7:0] exp_load;
        do_reset();
        poke_en = 1'b1; poke_idx = 3'd0; poke_val = 8'h11;
        tick();
        poke_en = 1'b0;
        scrub_en = 1'b1;
        n = 0;
        while (cfg_load === 8'h00 && n < 40) begin tick(); n++; end
        checks++; if (n !== 17) begin errors++; $display("FAIL scrub_first_delay got=%0d exp=17", n); end
        checks++; if (cfg_load !== 8'h01) begin errors++; $display("FAIL scrub_first_load got=%h exp=01", cfg_load); end
        checks++; if (cfg_din !== 8'h11) begin errors++; $display("FAIL scrub_first_din got=%h exp=11", cfg_din); end
        for (int k = 1; k <= 8; k++) begin
            n = 0;
            do begin tick(); n++; end while (cfg_load === 8'h00 && n < 40);
            exp_load = 8'(1 << (k % 8));
            checks++; if (n !== 16) begin errors++; $display("FAIL scrub_period[%0d] got=%0d exp=16", k, n); end
            checks++; if (cfg_load !== exp_load) begin errors++; $display("FAIL scrub_ptr[%0d] got=%h exp=%h", k, cfg_load, exp_load); end
            checks++; if (cfg_din !== cells[k % 8]) begin errors++; $display("FAIL scrub_din[%0d] got=%h exp=%h", k, cfg_din, cells[k % 8]); end
        end
        tick();
        checks++; if (cells[0] !== 8'h11) begin errors++; $display("FAIL scrub_cell0 got=%h exp=11", cells[0]); end
        checks++; if (cells[3] !== 8'hA5) begin errors++; $display("FAIL scrub_cell3 got=%h exp=a5", cells[3]); end
        scrub_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        do_reset();
        scrub_en = 1'b1;
        repeat (16) tick();
        checks++; if (cfg_load !== 8'h00) begin errors++; $display("FAIL b2b_idle_load got=%h exp=00", cfg_load); end
        cmd_valid = 1'b1; cmd_addr = 4'd2; cmd_data = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cfg_load !== 8'h04) begin errors++; $display("FAIL b2b_cmd_wins got=%h exp=04", cfg_load); end
        checks++; if (cfg_din !== 8'h5A) begin errors++; $display("FAIL b2b_din got=%h exp=5a", cfg_din); end
        tick();
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        checks++; if (cfg_load !== 8'h00) begin errors++; $display("FAIL b2b_no_load got=%h exp=00", cfg_load); end
        tick();
        checks++; if (cfg_load !== 8'h01) begin errors++; $display("FAIL b2b_scrub_load got=%h exp=01", cfg_load); end
        checks++; if (cfg_din !== 8'h11) begin errors++; $display("FAIL b2b_scrub_din got=%h exp=11", cfg_din); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_scrub_ready got=%b exp=0", cmd_ready); end
        tick();
        checks++; if (cells[2] !== 8'h5A) begin errors++; $display("FAIL b2b_cell2 got=%h exp=5a", cells[2]); end
        scrub_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        // Abort during LOAD: strobe must drop without waiting for a clock
        cmd_valid = 1'b1; cmd_addr = 4'd1; cmd_data = 8'h77;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cfg_load !== 8'h02) begin errors++; $display("FAIL rst_pre_load got=%h exp=02", cfg_load); end
        rstn = 1'b0;
        #1;
        checks++; if (cfg_load !== 8'h00) begin errors++; $display("FAIL rst_async_load got=%h exp=00", cfg_load); end
        #2;
        rstn = 1'b1;
        tick();
        // Abort during CHECK with err set beforehand
        cmd_valid = 1'b1; cmd_addr = 4'd15;
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rst_pre_err got=%b exp=1", err); end
        cmd_addr = 4'd1; cmd_data = 8'h77;
        tick();
        cmd_valid = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        checks++; if (cfg_load !== 8'h00) begin errors++; $display("FAIL rst_chk_load got=%h exp=00", cfg_load); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_chk_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_chk_err got=%b exp=0", err); end
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_release_done got=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_late_done got=%b exp=0", done); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_retry();
        test_bad_addr();
        test_scrub();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
